// File: rtl/fetch_queue.sv
// fetch_queue
// -----------------------------------------------------------------------------
// Instruction fetch stage in front of the decoder. Keeps the PC, issues
// sequential reads to a 1-cycle-latency instruction ROM, and buffers the
// returned 16-bit words (tagged with their PC) in a small FIFO. The head of
// the FIFO goes to decode over a valid/ready handshake. Fetch stops after a
// halt opcode (low nibble 4'hF) and restarts on a redirect.
//
// Ports:
//   clk          in   clock, all state updates on the rising edge
//   rst          in   synchronous active-high reset
//   imem_req     out  ROM read request this cycle
//   imem_addr    out  ROM word address (current pc)
//   imem_data    in   ROM data, valid the cycle after imem_req
//   instr        out  head-of-queue instruction word
//   instr_pc     out  PC of instr
//   instr_valid  out  queue non-empty
//   instr_ready  in   decoder accepts the head this cycle
//   redirect     in   flush the queue and restart fetch at redirect_pc
//   redirect_pc  in   restart address
//   halted       out  fetch stopped by a halt opcode
// -----------------------------------------------------------------------------
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 8
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_data,
  output logic [15:0]     instr,
  output logic [PC_W-1:0] instr_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            halted
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  // Architectural state
  logic [PC_W-1:0]  pc_r;
  logic [15:0]      word_mem_r [DEPTH];
  logic [PC_W-1:0]  pc_mem_r   [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             rsp_pending_r;
  logic [PC_W-1:0]  rsp_pc_r;
  logic             halted_r;

  // Per-cycle decisions
  logic             pop_s;
  logic             push_s;
  logic             halt_detect_s;
  logic             req_s;
  logic [OCC_W-1:0] occupancy_s;
  logic [CNT_W-1:0] count_next_s;

  // Handshake, response capture, halt detection and the credit check.
  always_comb begin
    instr_valid   = (count_r != {CNT_W{1'b0}});
    pop_s         = instr_valid & instr_ready;
    push_s        = rsp_pending_r & ~redirect;
    halt_detect_s = rsp_pending_r & (imem_data[3:0] == 4'hF);
    // Slots committed after this cycle: buffered + in flight - leaving now.
    // A new request is only allowed if its response will have a free slot.
    occupancy_s   = OCC_W'(count_r) + OCC_W'(rsp_pending_r) - OCC_W'(pop_s);
    req_s         = ~rst & ~redirect & ~halted_r & ~halt_detect_s &
                    (occupancy_s < OCC_W'(DEPTH));
  end

  // Next occupancy from the push/pop combination (simultaneous = unchanged).
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_W'(1);
      2'b01:   count_next_s = count_r - CNT_W'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Control state: pc, pointers, count, in-flight tracking and halt flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r          <= {PC_W{1'b0}};
      rd_ptr_r      <= {PTR_W{1'b0}};
      wr_ptr_r      <= {PTR_W{1'b0}};
      count_r       <= {CNT_W{1'b0}};
      rsp_pending_r <= 1'b0;
      rsp_pc_r      <= {PC_W{1'b0}};
      halted_r      <= 1'b0;
    end else if (redirect) begin
      // Flush: the queue, any in-flight response and a pending pop are dropped.
      pc_r          <= redirect_pc;
      rd_ptr_r      <= {PTR_W{1'b0}};
      wr_ptr_r      <= {PTR_W{1'b0}};
      count_r       <= {CNT_W{1'b0}};
      rsp_pending_r <= 1'b0;
      halted_r      <= 1'b0;
    end else begin
      if (req_s) begin
        rsp_pending_r <= 1'b1;
        rsp_pc_r      <= pc_r;
        pc_r          <= pc_r + PC_W'(1);
      end else begin
        rsp_pending_r <= 1'b0;
      end
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_next_s;
      if (halt_detect_s) begin
        halted_r <= 1'b1;
      end
    end
  end

  // FIFO storage; the credit check guarantees the tail slot is free on push.
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      word_mem_r[wr_ptr_r] <= imem_data;
      pc_mem_r[wr_ptr_r]   <= rsp_pc_r;
    end
  end

  // Outputs: head comes straight from FIFO storage, never from imem_data.
  always_comb begin
    imem_req  = req_s;
    imem_addr = pc_r;
    instr     = word_mem_r[rd_ptr_r];
    instr_pc  = pc_mem_r[rd_ptr_r];
    halted    = halted_r;
  end

endmodule
